mem_check_ctrl: RTL and testbench

MEM_CHECK_CTRL -- requirements
Module: mem_check_ctrl

---
 rtl/mem_check_ctrl_if.sv | 29 ++
 rtl/mem_check_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mem_check_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_check_ctrl_if.sv
// RAM-side bus of the memory check controller.
// master: the controller (drives addresses, write data and write enable).
// slave:  the RAM (returns read data one cycle after raddr).
interface mem_check_ctrl_if #(
   parameter int WID_MEM = 4,
   parameter int ADDR_W  = 14
) ();
   logic [ADDR_W-1:0]  raddr;
   logic [ADDR_W-1:0]  waddr;
   logic [WID_MEM-1:0] din;
   logic               mem_we;
   logic [WID_MEM-1:0] dout;

   modport master (
      output raddr,
      output waddr,
      output din,
      output mem_we,
      input  dout
   );

   modport slave (
      input  raddr,
      input  waddr,
      input  din,
      input  mem_we,
      output dout
   );
endinterface

// File: rtl/mem_check_ctrl.sv
// mem_check_ctrl: sweeps a RAM either writing a seeded incrementing pattern
// (FILL) or reading it back and counting mismatches (VERIFY).
// Expected word at address A is (seed + A) truncated to WID_MEM bits.
// Optional first-mismatch capture is built only when the macro
// MEM_CHECK_FIRST_ERR_EN is defined; otherwise first_err_* are tied to 0.
module mem_check_ctrl #(
   parameter int WID_MEM   = 4,
   parameter int DEPTH_MEM = 16384,
   parameter int ADDR_W    = 14
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                mode,
   input  logic [WID_MEM-1:0]  seed,
   mem_check_ctrl_if.master    mem,
   output logic                busy,
   output logic                done,
   output logic [15:0]         err_cnt,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic [WID_MEM-1:0]  first_err_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   // Last swept address; comparing against it stops the counter without
   // ever wrapping, even when DEPTH_MEM fills the whole address space.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

   state_t              state_q,   state_d;
   logic [ADDR_W-1:0]   cnt_q,     cnt_d;
   logic [WID_MEM-1:0]  seed_q,    seed_d;
   logic [ADDR_W-1:0]   raddr_q,   raddr_d;
   logic [ADDR_W-1:0]   waddr_q,   waddr_d;
   logic [WID_MEM-1:0]  din_q,     din_d;
   logic                mem_we_q,  mem_we_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;
   logic [15:0]         err_cnt_q, err_cnt_d;
   // cmp_vld_q marks the cycle in which dout belongs to cmp_addr_q
   logic                cmp_vld_q, cmp_vld_d;
   logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
   logic [ADDR_W-1:0]   cnt_inc;
   logic                mismatch;

`ifdef MEM_CHECK_FIRST_ERR_EN
   logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
   logic [WID_MEM-1:0]  ferr_data_q, ferr_data_d;
`endif

   function automatic logic [WID_MEM-1:0] pattern(
      input logic [WID_MEM-1:0] s,
      input logic [ADDR_W-1:0]  a
   );
      logic [ADDR_W+WID_MEM-1:0] ext;
      ext = {{WID_MEM{1'b0}}, a};
      return s + ext[WID_MEM-1:0];
   endfunction

   assign cnt_inc  = cnt_q + 1'b1;
   assign mismatch = cmp_vld_q && (mem.dout != pattern(seed_q, cmp_addr_q));

   // Next-state and next-output computation for the sweep FSM and checker.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      seed_d     = seed_q;
      raddr_d    = raddr_q;
      waddr_d    = waddr_q;
      din_d      = din_q;
      mem_we_d   = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_cnt_d  = err_cnt_q;
      cmp_vld_d  = 1'b0;
      cmp_addr_d = cmp_addr_q;
`ifdef MEM_CHECK_FIRST_ERR_EN
      ferr_addr_d = ferr_addr_q;
      ferr_data_d = ferr_data_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               seed_d = seed;
               cnt_d  = '0;
               busy_d = 1'b1;
               if (!mode) begin
                  state_d  = S_FILL;
                  mem_we_d = 1'b1;
                  waddr_d  = '0;
                  din_d    = pattern(seed, {ADDR_W{1'b0}});
               end else begin
                  state_d   = S_READ;
                  raddr_d   = '0;
                  err_cnt_d = '0;
`ifdef MEM_CHECK_FIRST_ERR_EN
                  ferr_addr_d = '0;
                  ferr_data_d = '0;
`endif
               end
            end
         end
         S_FILL: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d    = cnt_inc;
               mem_we_d = 1'b1;
               waddr_d  = cnt_inc;
               din_d    = pattern(seed_q, cnt_inc);
            end
         end
         S_READ: begin
            // the address presented this cycle is checked next cycle
            cmp_vld_d  = 1'b1;
            cmp_addr_d = cnt_q;
            if (cnt_q == LAST_ADDR) begin
               state_d = S_DRAIN;
            end else begin
               cnt_d   = cnt_inc;
               raddr_d = cnt_inc;
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // cmp_vld_q is only ever set in READ/DRAIN, so this never races the
      // clearing done on a VERIFY start.
      if (mismatch) begin
         if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
`ifdef MEM_CHECK_FIRST_ERR_EN
         if (err_cnt_q == 16'd0) begin
            ferr_addr_d = cmp_addr_q;
            ferr_data_d = mem.dout;
         end
`endif
      end
   end

   // State and registered outputs; reset aborts any sweep without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         seed_q     <= '0;
         raddr_q    <= '0;
         waddr_q    <= '0;
         din_q      <= '0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_cnt_q  <= '0;
         cmp_vld_q  <= 1'b0;
         cmp_addr_q <= '0;
`ifdef MEM_CHECK_FIRST_ERR_EN
         ferr_addr_q <= '0;
         ferr_data_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         seed_q     <= seed_d;
         raddr_q    <= raddr_d;
         waddr_q    <= waddr_d;
         din_q      <= din_d;
         mem_we_q   <= mem_we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_cnt_q  <= err_cnt_d;
         cmp_vld_q  <= cmp_vld_d;
         cmp_addr_q <= cmp_addr_d;
`ifdef MEM_CHECK_FIRST_ERR_EN
         ferr_addr_q <= ferr_addr_d;
         ferr_data_q <= ferr_data_d;
`endif
      end
   end

   assign mem.raddr  = raddr_q;
   assign mem.waddr  = waddr_q;
   assign mem.din    = din_q;
   assign mem.mem_we = mem_we_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err_cnt    = err_cnt_q;

`ifdef MEM_CHECK_FIRST_ERR_EN
   assign first_err_addr = ferr_addr_q;
   assign first_err_data = ferr_data_q;
`else
   assign first_err_addr = '0;
   assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_mem_check_ctrl.sv
// Testbench for mem_check_ctrl with a 16 x 4-bit behavioural RAM.
module tb_mem_check_ctrl;
   localparam int W  = 4;
   localparam int AW = 4;
   localparam int D  = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          mode;
   logic [W-1:0]  seed;
   logic          busy;
   logic          done;
   logic [15:0]   err_cnt;
   logic [AW-1:0] first_err_addr;
   logic [W-1:0]  first_err_data;

   mem_check_ctrl_if #(.WID_MEM(W), .ADDR_W(AW)) mem_if ();

   mem_check_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .ADDR_W(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .mode           (mode),
      .seed           (seed),
      .mem            (mem_if.master),
      .busy           (busy),
      .done           (done),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr),
      .first_err_data (first_err_data)
   );

   always #5 clk = ~clk;

   // Behavioural RAM, 1-cycle read latency. ram_cmd: 1 = corrupt words 5 and 9,
   // 2 = zero everything and clear the write-tracking flags.
   logic [W-1:0] ram [D];
   logic         wr_flag [D];
   logic [1:0]   ram_cmd;

   always @(posedge clk) begin
      if (ram_cmd == 2'd2) begin
         for (int i = 0; i < D; i++) begin
            ram[i]     <= '0;
            wr_flag[i] <= 1'b0;
         end
      end else if (ram_cmd == 2'd1) begin
         ram[5] <= '0;
         ram[9] <= '0;
      end else if (mem_if.mem_we) begin
         ram[mem_if.waddr]     <= mem_if.din;
         wr_flag[mem_if.waddr] <= 1'b1;
      end
      mem_if.dout <= ram[mem_if.raddr];
   end

   typedef struct {
      logic        mode;
      logic [3:0]  seed;
      int          pre;     // ram_cmd issued before the operation (0 = none)
      logic        pulse;   // extra start pulses while busy
      logic [15:0] exp_err;
      logic [3:0]  exp_faddr;
      logic [3:0]  exp_fdata;
   } vec_t;

   typedef struct {
      int          lat;
      int          busy_cyc;
      logic        mode;
      logic [3:0]  seed;
      logic [15:0] err;
      logic [3:0]  faddr;
      logic [3:0]  fdata;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic ram_op(input logic [1:0] cmd);
      @(negedge clk);
      ram_cmd = cmd;
      @(negedge clk);
      ram_cmd = 2'd0;
   endtask

   task automatic check_first(input string tag, input int a, input int d);
`ifdef MEM_CHECK_FIRST_ERR_EN
      check({tag, "_first_addr"}, int'(first_err_addr), a);
      check({tag, "_first_data"}, int'(first_err_data), d);
`else
      check({tag, "_first_addr_tied"}, int'(first_err_addr), 0);
      check({tag, "_first_data_tied"}, int'(first_err_data), 0);
`endif
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      exp_t  e;
      exp_t  got;
      int    cyc;
      int    bcyc;
      bit    seen;
      string tag;
      tag = $sformatf("op%0d", idx);
      if (v.pre != 0) ram_op(v.pre[1:0]);
      e.lat      = v.mode ? D + 2 : D + 1;
      e.busy_cyc = v.mode ? D + 1 : D;
      e.mode     = v.mode;
      e.seed     = v.seed;
      e.err      = v.exp_err;
      e.faddr    = v.exp_faddr;
      e.fdata    = v.exp_fdata;
      @(negedge clk);
      start = 1'b1;
      mode  = v.mode;
      seed  = v.seed;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      bcyc  = 0;
      seen  = 1'b0;
      while (cyc < 100 && !seen) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) bcyc++;
            start = v.pulse && (cyc == 5 || cyc == 9);
            mode  = ~v.mode;
            seed  = ~v.seed;
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!seen) begin
         check({tag, "_done_timeout"}, cyc, e.lat);
         return;
      end
      check({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
      if (sb.size() == 0) return;
      got = sb.pop_front();
      check({tag, "_latency"}, cyc, got.lat);
      check({tag, "_busy_cycles"}, bcyc, got.busy_cyc);
      check({tag, "_busy_in_done"}, int'(busy), 0);
      check({tag, "_we_in_done"}, int'(mem_if.mem_we), 0);
      if (got.mode) begin
         check({tag, "_err_cnt"}, int'(err_cnt), int'(got.err));
         check_first(tag, int'(got.faddr), int'(got.fdata));
      end else begin
         for (int a = 0; a < D; a++) begin
            check($sformatf("%s_ram%0d", tag, a), int'(ram[a]), int'(4'(got.seed + 4'(a))));
            check($sformatf("%s_wr%0d", tag, a), int'(wr_flag[a]), 1);
         end
      end
      @(negedge clk);
      check({tag, "_done_one_cycle"}, int'(done), 0);
      if (got.mode) check({tag, "_err_hold"}, int'(err_cnt), int'(got.err));
      $display("op%0d mode=%0d seed=%0h latency=%0d busy=%0d err_cnt=%0d", idx, got.mode, got.seed, cyc, bcyc, err_cnt);
   endtask

   vec_t vecs[7];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  done_cnt;
      vec_t v;
      vecs[0] = '{mode:1'b0, seed:4'h3, pre:2, pulse:1'b0, exp_err:16'd0,  exp_faddr:4'd0, exp_fdata:4'd0};
      vecs[1] = '{mode:1'b1, seed:4'h3, pre:0, pulse:1'b0, exp_err:16'd0,  exp_faddr:4'd0, exp_fdata:4'd0};
      vecs[2] = '{mode:1'b1, seed:4'h3, pre:1, pulse:1'b0, exp_err:16'd2,  exp_faddr:4'd5, exp_fdata:4'd0};
      vecs[3] = '{mode:1'b1, seed:4'h3, pre:2, pulse:1'b1, exp_err:16'd15, exp_faddr:4'd0, exp_fdata:4'd0};
      vecs[4] = '{mode:1'b0, seed:4'hA, pre:0, pulse:1'b1, exp_err:16'd0,  exp_faddr:4'd0, exp_fdata:4'd0};
      vecs[5] = '{mode:1'b1, seed:4'hB, pre:0, pulse:1'b0, exp_err:16'd16, exp_faddr:4'd0, exp_fdata:4'hA};
      vecs[6] = '{mode:1'b1, seed:4'hA, pre:0, pulse:1'b0, exp_err:16'd0,  exp_faddr:4'd0, exp_fdata:4'd0};

      reset   = 1'b1;
      start   = 1'b0;
      mode    = 1'b0;
      seed    = '0;
      ram_cmd = 2'd2;
      repeat (3) @(negedge clk);
      ram_cmd = 2'd0;
      check("rst_busy",    int'(busy), 0);
      check("rst_done",    int'(done), 0);
      check("rst_we",      int'(mem_if.mem_we), 0);
      check("rst_raddr",   int'(mem_if.raddr), 0);
      check("rst_waddr",   int'(mem_if.waddr), 0);
      check("rst_din",     int'(mem_if.din), 0);
      check("rst_err_cnt", int'(err_cnt), 0);
      check_first("rst", 0, 0);
      $display("reset: busy=%0d done=%0d err_cnt=%0d", busy, done, err_cnt);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         run_vec(i, v);
      end

      // Reset in cycle 6 of a FILL aborts it after words 0..5 were written.
      ram_op(2'd2);
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b0;
      seed  = 4'h3;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy",    int'(busy), 0);
      check("abort_done",    int'(done), 0);
      check("abort_we",      int'(mem_if.mem_we), 0);
      check("abort_raddr",   int'(mem_if.raddr), 0);
      check("abort_waddr",   int'(mem_if.waddr), 0);
      check("abort_din",     int'(mem_if.din), 0);
      check("abort_err_cnt", int'(err_cnt), 0);
      check_first("abort", 0, 0);
      done_cnt = 0;
      for (int c = 0; c < 25; c++) begin
         if (done || busy) done_cnt++;
         @(negedge clk);
      end
      check("abort_no_done", done_cnt, 0);
      for (int a = 0; a < D; a++) begin
         check($sformatf("abort_wr%0d", a), int'(wr_flag[a]), (a < 6) ? 1 : 0);
      end
      $display("abort: busy=%0d done=%0d activity_after_reset=%0d", busy, done, done_cnt);
      v = '{mode:1'b0, seed:4'h3, pre:0, pulse:1'b0, exp_err:16'd0, exp_faddr:4'd0, exp_fdata:4'd0};
      run_vec(7, v);

      // reset and start together: start must be ignored.
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      mode  = 1'b1;
      seed  = 4'h5;
      @(negedge clk);
      check("rst_start_busy", int'(busy), 0);
      check("rst_start_we",   int'(mem_if.mem_we), 0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_start_idle_busy", int'(busy), 0);
      check("rst_start_idle_done", int'(done), 0);
      $display("reset+start: busy=%0d done=%0d", busy, done);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
